// File: rtl/feature_norm_packer.sv
// ---------------------------------------------------------------------------
// feature_norm_packer
//
// Front end of the RBF-kernel SVM classifier. Takes a serial stream of raw
// signed fixed-point market features (one per handshake), normalises each one
// as (x - mean[i]) * inv_std[i] with saturation, and packs a complete frame of
// NUM_FEATURES lanes into a flat vector that is presented with a one-cycle
// valid pulse. Framing is enforced with in_last; a frame that ends early or
// runs past its last lane is discarded and a frame_error pulse is raised.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous, active-low reset
//   in_valid       input sample valid
//   in_ready       block can accept a sample (registered, high after reset)
//   in_data        signed raw feature
//   in_last        marks the final feature of a frame
//   mean_flat      per-lane mean, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   inv_std_flat   per-lane 1/std, same lane packing
//   out_valid      one-cycle pulse: features_flat holds a new complete frame
//   features_flat  normalised packed frame, held until the next good frame
//   frame_error    one-cycle pulse on a framing violation
//   frame_count    number of frames emitted, wraps at 16 bits
// ---------------------------------------------------------------------------
module feature_norm_packer #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int NUM_FEATURES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0]   mean_flat,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0]   inv_std_flat,
  output logic                                 out_valid,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0]   features_flat,
  output logic                                 frame_error,
  output logic [15:0]                          frame_count
);

  localparam int IDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int FLAT_W = DATA_WIDTH * NUM_FEATURES;
  localparam int PROD_W = 2 * DATA_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  // Saturation bounds expressed at product width so the compare is exact.
  localparam logic signed [PROD_W-1:0] MAX_V =
    {{(DATA_WIDTH+1){1'b0}}, 1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MIN_V =
    {{(DATA_WIDTH+1){1'b1}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    COLLECT = 1'b0,
    DROP    = 1'b1
  } state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic                          accept;

  logic signed [DATA_WIDTH-1:0]  mean_lane;
  logic signed [DATA_WIDTH-1:0]  inv_std_lane;

  // Stage-1 registers: the accepted sample plus the lane coefficients that
  // were current when it was accepted.
  logic                          s1_write;
  logic                          s1_emit;
  logic [IDX_W-1:0]              s1_idx;
  logic signed [DATA_WIDTH-1:0]  s1_data;
  logic signed [DATA_WIDTH-1:0]  s1_mean;
  logic signed [DATA_WIDTH-1:0]  s1_inv_std;

  logic signed [DATA_WIDTH:0]    diff;
  logic signed [PROD_W-1:0]      prod;
  logic signed [PROD_W-1:0]      scaled;
  logic signed [DATA_WIDTH-1:0]  sat;

  logic [FLAT_W-1:0]             assembly;
  logic [FLAT_W-1:0]             assembly_next;

  assign accept       = in_valid && in_ready;
  assign mean_lane    = mean_flat[idx*DATA_WIDTH +: DATA_WIDTH];
  assign inv_std_lane = inv_std_flat[idx*DATA_WIDTH +: DATA_WIDTH];

  // Framing state machine and acceptance stage. The frame decision is made
  // here at acceptance and travels with the sample into stage 1; the error
  // pulse is raised straight from that decision so it lands one cycle after
  // the offending sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      idx         <= '0;
      in_ready    <= 1'b0;
      frame_error <= 1'b0;
      s1_write    <= 1'b0;
      s1_emit     <= 1'b0;
      s1_idx      <= '0;
      s1_data     <= '0;
      s1_mean     <= '0;
      s1_inv_std  <= '0;
    end else begin
      in_ready    <= 1'b1;
      frame_error <= 1'b0;
      s1_write    <= 1'b0;
      s1_emit     <= 1'b0;
      if (accept) begin
        s1_idx     <= idx;
        s1_data    <= in_data;
        s1_mean    <= mean_lane;
        s1_inv_std <= inv_std_lane;
        case (state)
          COLLECT: begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (in_last) begin
                s1_write <= 1'b1;
                s1_emit  <= 1'b1;
              end else begin
                frame_error <= 1'b1;
                state       <= DROP;
              end
            end else if (in_last) begin
              frame_error <= 1'b1;
              idx         <= '0;
            end else begin
              s1_write <= 1'b1;
              idx      <= idx + 1'b1;
            end
          end
          DROP: begin
            if (in_last) begin
              state <= COLLECT;
              idx   <= '0;
            end
          end
          default: begin
            state <= COLLECT;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  // Normalisation datapath. Operands are sign-extended before the subtract
  // and multiply so neither can overflow; the shift is arithmetic, so the
  // result truncates toward minus infinity.
  always_comb begin
    diff   = (DATA_WIDTH+1)'(s1_data) - (DATA_WIDTH+1)'(s1_mean);
    prod   = PROD_W'(diff) * PROD_W'(s1_inv_std);
    scaled = prod >>> FRAC_BITS;
    if (scaled > MAX_V) begin
      sat = MAX_V[DATA_WIDTH-1:0];
    end else if (scaled < MIN_V) begin
      sat = MIN_V[DATA_WIDTH-1:0];
    end else begin
      sat = scaled[DATA_WIDTH-1:0];
    end
  end

  // Assembly image with the current stage-1 result already merged in. The
  // output copy uses this, so the final lane of a frame is captured on the
  // same edge it is written, and the next frame's first write lands one edge
  // later without disturbing the copy.
  always_comb begin
    assembly_next = assembly;
    assembly_next[s1_idx*DATA_WIDTH +: DATA_WIDTH] = sat;
  end

  // Assembly and output stage. features_flat only moves on a complete,
  // correctly framed frame; discarded frames leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assembly      <= '0;
      features_flat <= '0;
      out_valid     <= 1'b0;
      frame_count   <= '0;
    end else begin
      out_valid <= s1_emit;
      if (s1_write) begin
        assembly <= assembly_next;
      end
      if (s1_emit) begin
        features_flat <= assembly_next;
        frame_count   <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_feature_norm_packer.sv
// ---------------------------------------------------------------------------
// tb_feature_norm_packer
//
// Directed bench for feature_norm_packer: reset values, passthrough frame,
// scaling and saturation lanes, early/missing in_last recovery, back-to-back
// frames, and a reset in the middle of a frame. Expected vectors are written
// out by hand from the normalisation formula.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_feature_norm_packer;

  localparam int DW = 16;
  localparam int NF = 16;
  localparam int W  = DW * NF;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [W-1:0]  mean_flat;
  logic [W-1:0]  inv_std_flat;
  logic          out_valid;
  logic [W-1:0]  features_flat;
  logic          frame_error;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  int err_pulses   = 0;
  int pulse_cyc[$];
  logic [W-1:0] pulse_data[$];

  feature_norm_packer #(
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (8),
    .NUM_FEATURES(NF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .mean_flat    (mean_flat),
    .inv_std_flat (inv_std_flat),
    .out_valid    (out_valid),
    .features_flat(features_flat),
    .frame_error  (frame_error),
    .frame_count  (frame_count)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter plus the edge at which the most recent in_last was taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready && in_last) begin
      last_acc_cyc <= cyc;
    end
  end

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(features_flat);
    end
    if (frame_error) begin
      err_pulses <= err_pulses + 1;
    end
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] data, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_uniform(input logic [DW-1:0] m, input logic [DW-1:0] s);
    for (int i = 0; i < NF; i++) begin
      mean_flat[i*DW +: DW]    = m;
      inv_std_flat[i*DW +: DW] = s;
    end
  endtask

  task automatic set_lane(input int lane, input logic [DW-1:0] m, input logic [DW-1:0] s);
    mean_flat[lane*DW +: DW]    = m;
    inv_std_flat[lane*DW +: DW] = s;
  endtask

  initial begin
    logic [W-1:0]  exp_vec;
    logic [W-1:0]  prev_vec;
    logic [DW-1:0] sd [NF];
    int base_p;
    int base_e;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    set_uniform(16'h0000, 16'h0100);

    // Reset values
    wait_cycles(3);
    check_output("reset in_ready", W'(in_ready), W'(0));
    check_output("reset out_valid", W'(out_valid), W'(0));
    check_output("reset features_flat", features_flat, W'(0));
    check_output("reset frame_error", W'(frame_error), W'(0));
    check_output("reset frame_count", W'(frame_count), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("in_ready before first edge", W'(in_ready), W'(0));
    wait_cycles(1);
    check_output("in_ready after first edge", W'(in_ready), W'(1));

    // Passthrough: mean 0, inv_std 1.0
    $display("[TB] passthrough frame");
    for (int i = 0; i < NF; i++) apply_stimulus(16'(i * 16'h0100), i == NF - 1);
    go_idle();
    wait_cycles(4);
    check_output("passthrough pulse count", W'(pulse_cyc.size()), W'(1));
    if (pulse_cyc.size() >= 1) begin
      check_output("passthrough latency", W'(pulse_cyc[0] - last_acc_cyc), W'(2));
      for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(i * 16'h0100);
      check_output("passthrough pulse data", pulse_data[0], exp_vec);
    end
    for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(i * 16'h0100);
    check_output("passthrough features_flat", features_flat, exp_vec);
    check_output("passthrough frame_count", W'(frame_count), W'(1));

    // Scaling, saturation and rounding-direction lanes
    $display("[TB] scaling and saturation frame");
    for (int i = 0; i < NF; i++) sd[i] = 16'h0000;
    set_lane(0, 16'h0100, 16'h0080); sd[0] = 16'h0300;
    set_lane(1, 16'h0200, 16'h0100); sd[1] = 16'hFE00;
    set_lane(2, 16'h8000, 16'h0100); sd[2] = 16'h7FFF;
    set_lane(3, 16'h7FFF, 16'h0200); sd[3] = 16'h8000;
    set_lane(4, 16'h0000, 16'h0080); sd[4] = 16'hFFFF;
    set_lane(5, 16'h0000, 16'h0080); sd[5] = 16'h0001;
    for (int i = 0; i < NF; i++) apply_stimulus(sd[i], i == NF - 1);
    go_idle();
    wait_cycles(4);
    exp_vec = '0;
    exp_vec[0*DW +: DW] = 16'h0100;
    exp_vec[1*DW +: DW] = 16'hFC00;
    exp_vec[2*DW +: DW] = 16'h7FFF;
    exp_vec[3*DW +: DW] = 16'h8000;
    exp_vec[4*DW +: DW] = 16'hFFFF;
    exp_vec[5*DW +: DW] = 16'h0000;
    check_output("scaling pulse count", W'(pulse_cyc.size()), W'(2));
    check_output("scaling features_flat", features_flat, exp_vec);
    check_output("scaling frame_count", W'(frame_count), W'(2));
    prev_vec = exp_vec;

    // Early last at idx 5
    $display("[TB] early last");
    set_uniform(16'h0000, 16'h0100);
    base_p = pulse_cyc.size();
    base_e = err_pulses;
    for (int i = 0; i < 6; i++) apply_stimulus(16'(16'h0500 + i), i == 5);
    go_idle();
    wait_cycles(4);
    check_output("early last error pulses", W'(err_pulses - base_e), W'(1));
    check_output("early last no out_valid", W'(pulse_cyc.size() - base_p), W'(0));
    check_output("early last features held", features_flat, prev_vec);
    check_output("early last frame_count", W'(frame_count), W'(2));
    for (int i = 0; i < NF; i++) apply_stimulus(16'(16'h0A00 + i), i == NF - 1);
    go_idle();
    wait_cycles(4);
    for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(16'h0A00 + i);
    check_output("after early last pulse count", W'(pulse_cyc.size() - base_p), W'(1));
    check_output("after early last features", features_flat, exp_vec);
    check_output("after early last frame_count", W'(frame_count), W'(3));
    prev_vec = exp_vec;

    // Missing last: 20 samples, last only on the 20th
    $display("[TB] missing last");
    base_p = pulse_cyc.size();
    base_e = err_pulses;
    for (int i = 0; i < 20; i++) apply_stimulus(16'(16'h0600 + i), i == 19);
    go_idle();
    wait_cycles(4);
    check_output("missing last error pulses", W'(err_pulses - base_e), W'(1));
    check_output("missing last no out_valid", W'(pulse_cyc.size() - base_p), W'(0));
    check_output("missing last features held", features_flat, prev_vec);
    for (int i = 0; i < NF; i++) apply_stimulus(16'(16'h0B00 + 3 * i), i == NF - 1);
    go_idle();
    wait_cycles(4);
    for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(16'h0B00 + 3 * i);
    check_output("after missing last features", features_flat, exp_vec);
    check_output("after missing last frame_count", W'(frame_count), W'(4));
    check_output("after missing last no new error", W'(err_pulses - base_e), W'(1));

    // Three back-to-back frames, mean 0x0010 on every lane
    $display("[TB] back-to-back frames");
    set_uniform(16'h0010, 16'h0100);
    base_p = pulse_cyc.size();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NF; i++)
        apply_stimulus(16'(f * 16'h1000 + i * 16'h0011 + 16'h0010), i == NF - 1);
    go_idle();
    wait_cycles(4);
    check_output("b2b pulse count", W'(pulse_cyc.size() - base_p), W'(3));
    if (pulse_cyc.size() >= base_p + 3) begin
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(f * 16'h1000 + i * 16'h0011);
        check_output($sformatf("b2b frame %0d data", f), pulse_data[base_p + f], exp_vec);
      end
      check_output("b2b spacing 0-1", W'(pulse_cyc[base_p + 1] - pulse_cyc[base_p]), W'(16));
      check_output("b2b spacing 1-2", W'(pulse_cyc[base_p + 2] - pulse_cyc[base_p + 1]), W'(16));
    end
    check_output("b2b frame_count", W'(frame_count), W'(7));

    // Fourth frame interrupted by reset at idx 7
    $display("[TB] reset mid-frame");
    base_p = pulse_cyc.size();
    base_e = err_pulses;
    for (int i = 0; i < 7; i++) apply_stimulus(16'(16'h0700 + i), 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0707;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_output("mid reset out_valid", W'(out_valid), W'(0));
    check_output("mid reset features_flat", features_flat, W'(0));
    check_output("mid reset frame_count", W'(frame_count), W'(0));
    check_output("mid reset in_ready", W'(in_ready), W'(0));
    wait_cycles(2);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    wait_cycles(10);
    check_output("post reset no out_valid", W'(pulse_cyc.size() - base_p), W'(0));
    check_output("post reset no frame_error", W'(err_pulses - base_e), W'(0));
    check_output("post reset features_flat", features_flat, W'(0));
    set_uniform(16'h0000, 16'h0100);
    for (int i = 0; i < NF; i++) apply_stimulus(16'(16'h0C00 + i), i == NF - 1);
    go_idle();
    wait_cycles(4);
    for (int i = 0; i < NF; i++) exp_vec[i*DW +: DW] = 16'(16'h0C00 + i);
    check_output("post reset frame features", features_flat, exp_vec);
    check_output("post reset frame_count", W'(frame_count), W'(1));
    check_output("post reset frame error free", W'(err_pulses - base_e), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_norm_packer.md
Name: feature_norm_packer

Overview:
- Upstream stage of the RBF-kernel SVM classifier.
- Accepts a serial stream of raw Q8.8 market features, one feature per handshake.
- Normalises each feature as (x - mean[i]) * inv_std[i] with saturation.
- Packs a complete frame of NUM_FEATURES lanes into a flat vector and presents it with a one-cycle valid pulse. That vector drives the classifier's features_flat/input_valid directly.
- Enforces frame framing via in_last and resynchronises after framing errors.

Parameters:
- DATA_WIDTH, 16: width of every feature/coefficient word, signed fixed point.
- FRAC_BITS, 8: fractional bits (Q8.8 at defaults).
- NUM_FEATURES, 16: features per frame; lane index i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_WIDTH  signed raw feature, Q8.8.
- in_last  in  1  marks final feature of a frame.
- mean_flat  in  DATA_WIDTH*NUM_FEATURES  signed per-lane mean, Q8.8, lane packing as above.
- inv_std_flat  in  DATA_WIDTH*NUM_FEATURES  signed per-lane 1/std, Q8.8.
- out_valid  out  1  one-cycle pulse: features_flat holds a new complete frame.
- features_flat  out  DATA_WIDTH*NUM_FEATURES  normalised packed frame, held until next frame.
- frame_error  out  1  one-cycle pulse on framing violation.
- frame_count  out  16  count of frames emitted, wraps 0xFFFF -> 0.

Behaviour:
- Reset values (async assert): in_ready=0, out_valid=0, features_flat=0, frame_error=0, frame_count=0, lane index idx=0, state=COLLECT, assembly register=0, pipeline valid=0.
- in_ready is registered. It goes 1 on the first clk edge after rst_n deasserts and stays 1; there is no other backpressure because the downstream classifier accepts every cycle. A sample is accepted when in_valid && in_ready.
- Arithmetic, per accepted sample at lane idx:
  - diff = in_data - mean[idx], computed at DATA_WIDTH+1 bits.
  - prod = diff * inv_std[idx], computed at 2*DATA_WIDTH+1 bits.
  - scaled = prod >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - Saturate scaled to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- mean/inv_std lanes are sampled at acceptance; changes mid-frame affect only later lanes.
- Pipeline:
  - Cycle T: accept sample; register in_data, idx, in_last, mean/inv_std lane and the state decision.
  - T+1: compute, saturate, write the assembly slot idx.
  - If the accepted sample completed a valid frame, at T+2: features_flat <= assembly (including slot written at T+1), out_valid=1 for exactly one cycle, frame_count+1.
- Back-to-back frames at one sample/cycle are sustained with no bubbles. The assembly slot writes of frame N+1 must not corrupt the frame N copy; the copy takes the T+1 write by bypass.
- State machine:
  - COLLECT, normal sample with idx<NUM_FEATURES-1 and in_last=0: write lane, idx+1.
  - COLLECT, idx==NUM_FEATURES-1 and in_last=1: frame complete, emit, idx=0.
  - COLLECT, in_last=1 with idx<NUM_FEATURES-1 (early last): partial frame discarded, no out_valid, frame_error pulse at T+1, idx=0, stay COLLECT.
  - COLLECT, idx==NUM_FEATURES-1 and in_last=0 (missing last): frame discarded, frame_error pulse at T+1, go DROP.
  - DROP: accepted samples ignored. On an accepted sample with in_last=1, go COLLECT with idx=0, no error pulse.
- features_flat is never updated except on a valid frame. Discarded frames leave the previous output intact.
- Reset mid-frame: all state cleared immediately, partial frame lost, no out_valid or frame_error generated by pre-reset samples.
- Unsigned 8-bit LUT addressing downstream is not this block's concern. The output is full signed Q8.8.

Test Plan:
- Passthrough: mean=0, inv_std=0x0100 all lanes; send in_data=i*0x0100 for i=0..15, last on i=15 -> out_valid pulse 2 cycles after last accept, lane i = i*0x0100, frame_count=1.
- Scaling: lane 0 in=0x0300, mean=0x0100, inv_std=0x0080 -> lane 0 = 0x0100. Lane 1 in=0xFE00, mean=0x0200, inv_std=0x0100 -> 0xFC00.
- Saturation: in=0x7FFF, mean=0x8000, inv_std=0x0100 -> 0x7FFF. in=0x8000, mean=0x7FFF, inv_std=0x0200 -> 0x8000.
- Early last at idx=5 -> frame_error pulse, no out_valid, previous features_flat unchanged; next correct 16-sample frame emits normally.
- Missing last: 20 samples with last only on sample 19 -> one frame_error, no out_valid, then a following good frame emits, frame_count+1.
- Back-to-back: 3 frames with continuous in_valid -> three out_valid pulses exactly 16 cycles apart, each frame's lanes correct. Assert rst_n low at idx=7 of a 4th frame -> outputs zero, no spurious pulse after release.
